pipe_skid_stage: RTL
====================

Name: pipe_skid_stage

Overview:
- Parametrised pipeline boundary register for the core. It is the next generation of the fixed IF/ID and ID/EX hold-only flop stages.
- Carries the instruction, the instruction address and a generic decoded payload.
- Adds a valid/ready handshake, a 2-entry skid buffer so upstream ready is fully registered, a flush that inserts a NOP bubble, and the legacy hold input.
- Instantiated between pc/id/executrol stages; one instance per boundary, payload width set per boundary.

Parameters:
- INST_W, 32, instruction width.
- ADDR_W, 32, instruction address width.
- PAYLOAD_W, 64, width of the decoded side-band bundle (imm, selects, operand data); legal range 1 to 1024.
- NOP_INST, 32'h0000_0013, value presented on out_inst when out_valid is low (addi x0,x0,0).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; driven directly from a flop.
- in_inst  in  INST_W  upstream instruction.
- in_addr  in  ADDR_W  upstream instruction address.
- in_payload  in  PAYLOAD_W  upstream side-band bundle.
- out_valid  out  1  downstream data valid.
- out_ready  in  1  downstream accepts.
- out_inst  out  INST_W  registered instruction; NOP_INST when !out_valid.
- out_addr  out  ADDR_W  registered address; 0 when !out_valid.
- out_payload  out  PAYLOAD_W  registered payload; 0 when !out_valid.
- hold  in  1  legacy stall from executrol; treated as downstream not ready.
- flush  in  1  jump/redirect; kill all held contents.
- perf_stall_cnt  out  32  cycles with out_valid && !(out_ready && !hold).
- perf_bubble_cnt  out  32  cycles with !out_valid && !hold.

Behaviour:
- Reset is sampled on the rising clk edge while rst==0, and takes priority over everything. It sets:
  - main_v=0, skid_v=0, in_ready=1
  - out_inst=NOP_INST, out_addr=0, out_payload=0
  - both perf counters=0
- Inputs are ignored during reset cycles.
- Internal signals:
  - rdy_eff = out_ready && !hold
  - pop = main_v && rdy_eff
  - push = in_valid && in_ready && !flush
- State is count of valid entries; out_valid = main_v.
  - EMPTY: push -> ONE, main<=in.
  - ONE: push&&pop -> ONE, main<=in. push&&!pop -> FULL, skid<=in. !push&&pop -> EMPTY. Neither -> hold.
  - FULL: pop -> ONE, main<=skid, skid_v<=0. in_ready is 0, so no push is possible.
- in_ready is registered:
  - next in_ready = !(next skid_v).
  - It deasserts the cycle after the stage enters FULL and reasserts the cycle after leaving it.
- Latency and throughput:
  - Latency is 1 cycle from accept to out_valid when the stage is EMPTY or popping.
  - Sustained throughput is 1 instruction per cycle with out_ready=1 and hold=0.
- Flush:
  - Has priority over push and pop: next state EMPTY, main_v=skid_v=0.
  - Data regs load NOP_INST/0/0 and in_ready=1 the next cycle.
  - An in_valid presented in the flush cycle is dropped, not accepted.
- Hold=1 with flush=0: no pop. Upstream may still fill the skid entry (ONE->FULL), then in_ready drops.
- Outputs are stable while out_valid && !rdy_eff: no data change and no glitch to NOP.
- The skid entry is never exposed directly; ordering is strictly FIFO.
- Perf counters increment per condition and saturate at 32'hFFFF_FFFF with no wrap. Flush does not clear them; only reset does.

Optional Feature:
- Macro CNM_PIPE_PERF_EN.
- Defined: the two saturating 32-bit counters are implemented as specified above.
- Undefined: no counter flops are built; perf_stall_cnt and perf_bubble_cnt are tied to 32'h0. All other behaviour is identical.

Decomposition:
- Shared package cnm_pipe_pkg holds:
  - the NOP_INST constant 32'h0000_0013
  - the 2-bit state encoding (EMPTY=0, ONE=1, FULL=2)
  - the perf counter width 32 and saturation constant
- One sub-module, cnm_sat_cnt:
  - ports: clk, rst, inc, 32-bit count
  - saturating counter, instantiated twice under CNM_PIPE_PERF_EN.

Test Plan:
- Reset with rst=0 for 2 cycles, then release -> out_valid=0, out_inst=32'h00000013, out_addr=0, in_ready=1, counters=0.
- Streaming: in_valid=1 and out_ready=1, inst=32'h00A00093 at addr 0x100, then 0x104 next cycle -> out_inst=32'h00A00093/out_addr=0x100 one cycle later, 0x104 the following cycle, in_ready stays 1.
- Backpressure: out_ready=0 while pushing A, B, C on consecutive cycles:
  - A lands in main, B in skid, in_ready=0 after B, C is held upstream.
  - Raising out_ready then gives output order A, B, C with no loss or duplication.
- Hold: out_ready=1 and hold=1 for 3 cycles with main valid -> outputs frozen, perf_stall_cnt=3 (macro on) / 0 (macro off). Release -> pop next edge.
- Flush in FULL with in_valid=1 on the same cycle -> next cycle out_valid=0, out_inst=32'h00000013, in_ready=1. The flush-cycle input never appears on the output.
- Saturation (macro on): force the stall condition for more than 2^32 cycles, or preload via bind -> perf_stall_cnt holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/cnm_pipe_pkg.sv
// Shared constants and types for the pipeline boundary stages.
// Optional perf counters are enabled with the CNM_PIPE_PERF_EN macro.
package cnm_pipe_pkg;

    localparam logic [31:0] CNM_NOP_INST = 32'h0000_0013;   // addi x0,x0,0

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    localparam int unsigned       PERF_W   = 32;
    localparam logic [PERF_W-1:0] PERF_SAT = '1;

endpackage

// File: rtl/cnm_sat_cnt.sv
// Saturating event counter used for the pipeline stage perf counters.
// Built only when CNM_PIPE_PERF_EN is defined.
module cnm_sat_cnt
    import cnm_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    logic [PERF_W-1:0] count_q;
    logic [PERF_W-1:0] count_d;

    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (inc && (count_q != PERF_SAT)) begin
            count_d = count_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline boundary register with valid/ready, 2-entry skid buffer, flush and hold.
// Perf counters are built only when CNM_PIPE_PERF_EN is defined.
module pipe_skid_stage
    import cnm_pipe_pkg::*;
#(
    parameter int unsigned       INST_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       PAYLOAD_W = 64,
    parameter logic [INST_W-1:0] NOP_INST  = INST_W'(CNM_NOP_INST)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INST_W-1:0]    in_inst,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INST_W-1:0]    out_inst,
    output logic [ADDR_W-1:0]    out_addr,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic                 hold,
    input  logic                 flush,
    output logic [PERF_W-1:0]    perf_stall_cnt,
    output logic [PERF_W-1:0]    perf_bubble_cnt
);

    skid_state_e          state_q;
    logic                 in_ready_q;
    logic [INST_W-1:0]    main_inst_q;
    logic [ADDR_W-1:0]    main_addr_q;
    logic [PAYLOAD_W-1:0] main_payload_q;
    logic [INST_W-1:0]    skid_inst_q;
    logic [ADDR_W-1:0]    skid_addr_q;
    logic [PAYLOAD_W-1:0] skid_payload_q;

    logic main_v;
    logic rdy_eff;
    logic pop;
    logic push;

    assign main_v  = (state_q != ST_EMPTY);
    assign rdy_eff = out_ready && !hold;
    assign pop     = main_v && rdy_eff;
    assign push    = in_valid && in_ready_q && !flush;

    // Main entry doubles as the output register, so it carries NOP/0/0 whenever empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_EMPTY;
            in_ready_q     <= 1'b1;
            main_inst_q    <= NOP_INST;
            main_addr_q    <= '0;
            main_payload_q <= '0;
        end else if (flush) begin
            state_q        <= ST_EMPTY;
            in_ready_q     <= 1'b1;
            main_inst_q    <= NOP_INST;
            main_addr_q    <= '0;
            main_payload_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_q        <= ST_ONE;
                        main_inst_q    <= in_inst;
                        main_addr_q    <= in_addr;
                        main_payload_q <= in_payload;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_inst_q    <= in_inst;
                        main_addr_q    <= in_addr;
                        main_payload_q <= in_payload;
                    end else if (push) begin
                        state_q    <= ST_FULL;
                        in_ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q        <= ST_EMPTY;
                        main_inst_q    <= NOP_INST;
                        main_addr_q    <= '0;
                        main_payload_q <= '0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_q        <= ST_ONE;
                        in_ready_q     <= 1'b1;
                        main_inst_q    <= skid_inst_q;
                        main_addr_q    <= skid_addr_q;
                        main_payload_q <= skid_payload_q;
                    end
                end
                default: begin
                    state_q        <= ST_EMPTY;
                    in_ready_q     <= 1'b1;
                    main_inst_q    <= NOP_INST;
                    main_addr_q    <= '0;
                    main_payload_q <= '0;
                end
            endcase
        end
    end

    // NOTE: skid data needs no reset; it is only read after state_q says it was loaded.
    always_ff @(posedge clk) begin
        if (rst && !flush && (state_q == ST_ONE) && push && !pop) begin
            skid_inst_q    <= in_inst;
            skid_addr_q    <= in_addr;
            skid_payload_q <= in_payload;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_v;
    assign out_inst    = main_inst_q;
    assign out_addr    = main_addr_q;
    assign out_payload = main_payload_q;

`ifdef CNM_PIPE_PERF_EN
    cnm_sat_cnt u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (main_v && !rdy_eff),
        .count (perf_stall_cnt)
    );

    cnm_sat_cnt u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!main_v && !hold),
        .count (perf_bubble_cnt)
    );
`else
    assign perf_stall_cnt  = '0;
    assign perf_bubble_cnt = '0;
`endif

endmodule
